// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default bus widths, the register count and the requester encoding.
package regfile_wb_arbiter_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

    // Requester identity, also used as the last-grant record.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the two writeback requesters, the arbiter and the register file.
//   a_*/b_*   : valid/ready write requests from requester A (ALU) and B (load)
//   wr_*      : single register-file write port
//   pending   : per-register flag, set while a queued write targets that register
// Modports: slave = arbiter side, master = requester/regfile side.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [2**ADDR_W-1:0] pending;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, wr_en, wr_reg, wr_data, pending
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, wr_en, wr_reg, wr_data, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small in-order FIFO holding {reg, data} writeback entries for one requester.
//   clk, rst            : clock, asynchronous active-high reset (empties FIFO)
//   push, pushData      : enqueue on the rising edge (ignored when full)
//   pop                 : dequeue head on the rising edge (ignored when empty)
//   headData            : current head entry
//   full, empty         : occupancy before this edge's push/pop
//   entryValid, entries : raw storage, so the owner can build a pending mask
module wb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            pushData,
    input  logic                        pop,
    output logic [WIDTH-1:0]            headData,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            entryValid,
    output logic [DEPTH-1:0][WIDTH-1:0] entries
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra wrap bit distinguishes full from empty when indices match.
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]            wrPtr, rdPtr;
    logic [IDX_W-1:0]            wrIdx, rdIdx;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        doPush, doPop;

    generate
        if (DEPTH > 1) begin : gIdx
            assign wrIdx = wrPtr[IDX_W-1:0];
            assign rdIdx = rdPtr[IDX_W-1:0];
        end else begin : gIdxSingle
            assign wrIdx = '0;
            assign rdIdx = '0;
        end
    endgenerate

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[PTR_W-1] != rdPtr[PTR_W-1]) && (wrIdx == rdIdx);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdIdx];
    assign entries  = mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            entryValid <= '0;
        end else begin
            if (doPop) begin
                rdPtr             <= rdPtr + 1'b1;
                entryValid[rdIdx] <= 1'b0;
            end
            if (doPush) begin
                wrPtr             <= wrPtr + 1'b1;
                entryValid[wrIdx] <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entryValid gates every use of it.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrIdx] <= pushData;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between writeback requesters
// A (ALU) and B (load). Each requester feeds a private wb_fifo; heads are
// granted round-robin, one write per cycle, popped on the edge the register
// file captures the write.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regfile_wb_arbiter_if.slave (requests, write port, pending mask)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int ZERO_DROP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int NREGS   = 2 ** ADDR_W;

    logic [ENTRY_W-1:0]                 headA, headB;
    logic                               fullA, fullB, emptyA, emptyB;
    logic [FIFO_DEPTH-1:0]              validA, validB;
    logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] entriesA, entriesB;
    logic [NREGS-1:0]                   pendA, pendB;
    logic                               zeroA, zeroB;
    logic                               aReady, bReady, aAccept;
    logic                               pushA, pushB;
    logic                               grantA, grantB;
    req_t                               lastGrant;

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) uFifoA (
        .clk(clk), .rst(rst),
        .push(pushA), .pushData({bus.a_reg, bus.a_data}), .pop(grantA),
        .headData(headA), .full(fullA), .empty(emptyA),
        .entryValid(validA), .entries(entriesA)
    );

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) uFifoB (
        .clk(clk), .rst(rst),
        .push(pushB), .pushData({bus.b_reg, bus.b_data}), .pop(grantB),
        .headData(headB), .full(fullB), .empty(emptyB),
        .entryValid(validB), .entries(entriesB)
    );

    // Per-FIFO pending masks; a head being popped still counts this cycle.
    always_comb begin
        pendA = '0;
        pendB = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (validA[i]) pendA[entriesA[i][ENTRY_W-1:DATA_W]] = 1'b1;
            if (validB[i]) pendB[entriesB[i][ENTRY_W-1:DATA_W]] = 1'b1;
        end
    end

    // Register-0 writes are handshaken but dropped, so they never conflict.
    assign zeroA = (ZERO_DROP != 0) && (bus.a_reg == '0);
    assign zeroB = (ZERO_DROP != 0) && (bus.b_reg == '0);

    // A register may be queued in only one FIFO at a time, which keeps the
    // register-file write order equal to acceptance order. A wins a same-cycle
    // tie on the same register. full is pre-pop so ready stays off the grant path.
    assign aReady  = !rst && !fullA && (zeroA || !pendB[bus.a_reg]);
    assign aAccept = bus.a_valid && aReady;
    assign bReady  = !rst && !fullB &&
                     (zeroB || (!pendA[bus.b_reg] &&
                                !(aAccept && (bus.a_reg == bus.b_reg))));
    assign pushA   = aAccept && !zeroA;
    assign pushB   = bus.b_valid && bReady && !zeroB;

    assign grantA = !emptyA && (emptyB || (lastGrant == REQ_B));
    assign grantB = !emptyB && (emptyA || (lastGrant == REQ_A));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= REQ_B;
        end else if (grantA) begin
            lastGrant <= REQ_A;
        end else if (grantB) begin
            lastGrant <= REQ_B;
        end
    end

    assign bus.a_ready = aReady;
    assign bus.b_ready = bReady;
    assign bus.wr_en   = grantA || grantB;
    assign bus.wr_reg  = grantA ? headA[ENTRY_W-1:DATA_W] : headB[ENTRY_W-1:DATA_W];
    assign bus.wr_data = grantA ? headA[DATA_W-1:0]       : headB[DATA_W-1:0];
    assign bus.pending = pendA | pendB;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    entry_t      qA[$];
    entry_t      qB[$];
    req_t        lastG;
    logic [15:0] rfExp[16];
    logic [15:0] rfDut[16];
    int          issued[$];
    bit          accA, accB;

    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(DEPTH), .ZERO_DROP(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        qA.delete();
        qB.delete();
        issued.delete();
        lastG = REQ_B;
        for (int i = 0; i < 16; i++) begin
            rfExp[i] = '0;
            rfDut[i] = '0;
        end
    endtask

    // One clock cycle: drive, predict from queues, compare, clock, advance model.
    task automatic doCycle(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                           input bit bv, input logic [3:0] br, input logic [15:0] bd,
                           output bit acceptedA, output bit acceptedB);
        logic [15:0] pA, pB;
        bit eA, eB, gA, gB, zA, zB;
        @(negedge clk);
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        #1;
        pA = '0;
        pB = '0;
        foreach (qA[i]) pA[qA[i].r] = 1'b1;
        foreach (qB[i]) pB[qB[i].r] = 1'b1;
        zA = (ar == 4'd0);
        zB = (br == 4'd0);
        eA = (qA.size() < DEPTH) && (zA || !pB[ar]);
        eB = (qB.size() < DEPTH) && (zB || (!pA[br] && !(av && eA && ar == br)));
        gA = (qA.size() > 0) && (qB.size() == 0 || lastG == REQ_B);
        gB = (qB.size() > 0) && !gA;
        checkVal("aReady", bus.a_ready, eA);
        checkVal("bReady", bus.b_ready, eB);
        checkVal("wrEn", bus.wr_en, gA || gB);
        checkVal("pending", bus.pending, pA | pB);
        if (gA) begin
            checkVal("wrRegA", bus.wr_reg, qA[0].r);
            checkVal("wrDataA", bus.wr_data, qA[0].d);
        end else if (gB) begin
            checkVal("wrRegB", bus.wr_reg, qB[0].r);
            checkVal("wrDataB", bus.wr_data, qB[0].d);
        end
        if (bus.wr_en === 1'b1) begin
            rfDut[bus.wr_reg] = bus.wr_data;
            issued.push_back(int'(bus.wr_reg));
        end
        @(posedge clk);
        if (gA) begin
            void'(qA.pop_front());
            lastG = REQ_A;
        end else if (gB) begin
            void'(qB.pop_front());
            lastG = REQ_B;
        end
        acceptedA = av && eA;
        acceptedB = bv && eB;
        if (acceptedA && !zA) begin
            qA.push_back('{r: ar, d: ad});
            rfExp[ar] = ad;
        end
        if (acceptedB && !zB) begin
            qB.push_back('{r: br, d: bd});
            rfExp[br] = bd;
        end
    endtask

    task automatic idle(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) doCycle(0, 4'd0, 16'd0, 0, 4'd0, 16'd0, x, y);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_reg = 4'd9;
        bus.b_valid = 1'b1; bus.b_reg = 4'd10;
        #1;
        checkVal("rstWrEn", bus.wr_en, 1'b0);
        checkVal("rstPending", bus.pending, 16'h0000);
        checkVal("rstAReady", bus.a_ready, 1'b0);
        checkVal("rstBReady", bus.b_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        clearModel();
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Single A write to r5.
        doCycle(1, 4'd5, 16'hBEEF, 0, 4'd0, 16'd0, accA, accB);
        idle(2);
        checkVal("singleRf5", rfDut[5], 16'hBEEF);

        // Contention after reset: A wins first.
        applyReset();
        doCycle(1, 4'd1, 16'h0011, 1, 4'd3, 16'h0033, accA, accB);
        doCycle(1, 4'd2, 16'h0022, 1, 4'd4, 16'h0044, accA, accB);
        idle(4);
        checkVal("orderCount", issued.size(), 4);
        if (issued.size() == 4) begin
            checkVal("order0", issued[0], 1);
            checkVal("order1", issued[1], 3);
            checkVal("order2", issued[2], 2);
            checkVal("order3", issued[3], 4);
        end

        // Reset with writes still queued.
        doCycle(1, 4'd6, 16'h0066, 1, 4'd8, 16'h0088, accA, accB);
        applyReset();
        idle(1);

        // Same-register tie on r7.
        doCycle(1, 4'd7, 16'hAAAA, 1, 4'd7, 16'hBBBB, accA, accB);
        checkVal("tieAccA", accA, 1'b1);
        checkVal("tieAccB", accB, 1'b0);
        accB = 1'b0;
        for (int i = 0; i < 8 && !accB; i++) begin
            doCycle(0, 4'd0, 16'd0, 1, 4'd7, 16'hBBBB, accA, accB);
        end
        checkVal("tieBAdmitted", accB, 1'b1);
        idle(3);
        checkVal("tieRf7", rfDut[7], 16'hBBBB);

        // Zero drop.
        doCycle(1, 4'd0, 16'h1234, 0, 4'd0, 16'd0, accA, accB);
        checkVal("zeroAcc", accA, 1'b1);
        idle(2);
        checkVal("zeroRf0", rfDut[0], 16'h0000);

        // Fill both FIFOs and keep pushing A until it must stall.
        doCycle(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909, accA, accB);
        doCycle(1, 4'd10, 16'h0A0A, 1, 4'd11, 16'h0B0B, accA, accB);
        doCycle(1, 4'd12, 16'h0C0C, 1, 4'd13, 16'h0D0D, accA, accB);
        doCycle(1, 4'd14, 16'h0E0E, 0, 4'd0, 16'd0, accA, accB);
        idle(6);

        // Randomized traffic over a narrow register range to provoke conflicts.
        for (int i = 0; i < 600; i++) begin
            doCycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)), 16'($urandom),
                    $urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)), 16'($urandom),
                    accA, accB);
        end
        idle(6);
        for (int r = 0; r < 16; r++) checkVal($sformatf("rf%0d", r), rfDut[r], rfExp[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WriteReg/DstReg/DstData) between two writeback requesters: A = ALU/execute writeback, B = memory/load writeback.
- Each requester has a valid/ready handshake into a private small FIFO; the block round-robins between FIFO heads, one write per cycle.
- Exports a per-register pending mask so decode can stall on writes that are still queued.

Parameters:
- DATA_W, 16, data width of the write port
- ADDR_W, 4, register index width (16 registers)
- FIFO_DEPTH, 2, entries per requester FIFO; must be a power of 2, >= 1
- ZERO_DROP, 1, 1 = writes to register 0 are accepted and silently discarded

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- a_valid  in  1  requester A presents a write
- a_ready  out  1  A write accepted on this edge when a_valid && a_ready
- a_reg  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B presents a write
- b_ready  out  1  B write accepted on this edge when b_valid && b_ready
- b_reg  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- wr_en  out  1  to RegisterFile WriteReg
- wr_reg  out  ADDR_W  to RegisterFile DstReg
- wr_data  out  DATA_W  to RegisterFile DstData
- pending  out  2**ADDR_W  bit r = 1 while any queued (unissued) write targets register r

Behaviour:
- Reset (asynchronous): both FIFOs are emptied, last_grant = B, pending = 0, and wr_en = 0 immediately. a_ready and b_ready are 0 while rst is high.
- Storage: FIFO contents and pointers are registered. wr_en/wr_reg/wr_data are combinational from the selected FIFO head. The pop happens on the same edge the register file captures the write.
- Latency:
  - A request accepted at edge E into an empty FIFO is presented on wr_* during the cycle after E.
  - The register file captures it at edge E+1 when granted.
- Grant:
  - Only one head non-empty: that head is granted.
  - Both heads non-empty: grant the requester opposite last_grant.
  - last_grant updates only on a grant. After reset, A wins the first contention.
  - wr_en = 1 iff some head is granted.
- Ready rules (ready may depend combinationally on the same-cycle valid/reg):
  - a_ready = !full_A && !(pending_B[a_reg]).
  - b_ready = !full_B && !(pending_A[b_reg]) && !(a_valid && a_ready && a_reg == b_reg).
  - Consequence: two in-flight writes to the same register never exist in different FIFOs, so regfile write order equals acceptance order. On a same-cycle tie, A is admitted first.
- Full with simultaneous pop: full_X counts occupancy before this edge's pop, so a full FIFO does not accept even while it is being popped. This keeps ready free of the grant path.
- ZERO_DROP=1 and reg == 0: the handshake completes normally (ready follows the rules above ignoring pending), but nothing is enqueued and pending[0] stays 0.
- pending = OR over all valid entries of both FIFOs of the one-hot(reg). An entry being popped this cycle still counts as pending in this cycle.
- Wrap-around: FIFO pointers are ADDR-free modulo FIFO_DEPTH with an extra wrap bit; full = depth entries, empty = 0 entries.
- Reset mid-operation discards all queued writes; no partial write is presented to the regfile after rst asserts.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, NUM_REGS = 2**ADDR_W, requester encoding REQ_A = 0, REQ_B = 1.
- Sub-module wb_fifo (entry = {reg, data}, sync push/pop, async reset, full/empty, per-entry valid bits exposed for pending), instantiated twice.
- Arbitration, ready logic and pending OR-reduction stay in the top.

Test Plan:
- Reset: assert rst mid-stream with 2 entries queued -> wr_en=0, pending=0, a_ready=b_ready=0 the same cycle. After release: a_ready=b_ready=1.
- Single A write: a_valid, a_reg=5, a_data=16'hBEEF at edge E -> next cycle wr_en=1, wr_reg=5, wr_data=BEEF, pending=16'h0020. Cycle after: wr_en=0, pending=0.
- Contention: both FIFOs hold 2 entries (A: r1,r2; B: r3,r4) -> write order r1, r3, r2, r4 on consecutive cycles, wr_en held high.
- Same-register tie: same cycle a_reg=b_reg=7 -> a_ready=1, b_ready=0. B is admitted only after A's r7 write issues; regfile r7 ends with B's data.
- Full: push 2 A entries with no pop possible (force B-only grants first) -> a_ready=0 until one A pop completes.
- Zero drop: a_reg=0, a_data=16'h1234 -> a_ready=1, no wr_en pulse, pending[0]=0.
